// File: rtl/sound_out_buffer.sv
// sound_out_buffer: elastic stereo FIFO with priming, shift-based volume and mute in front of the codec write port.
// Define SOUND_FADE_EN to build the gradual FADE_OUT/FADE_IN ramps; otherwise mute switches on the next edge.
module sound_out_buffer #(
  parameter int DEPTH        = 16,
  parameter int FADE_SAMPLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [23:0]            in_left,
  input  logic [23:0]            in_right,
  output logic                   in_ready,
  input  logic [2:0]             volume,
  input  logic                   mute,
  input  logic                   write_ready,
  output logic                   write,
  output logic [23:0]            writedata_left,
  output logic [23:0]            writedata_right,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] ATT_MAX = 5'd24;

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FADE_SAMPLES < 1) begin : g_bad_params
      $error("sound_out_buffer: DEPTH must be a power of two >= 4 and FADE_SAMPLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {PLAY, FADE_OUT, MUTED, FADE_IN} gain_state_t;

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          primed_reg;
  logic          underflow_reg;
  gain_state_t   state_reg;
  logic [4:0]    att_reg;
  logic          push;
  logic          pop;
  logic [47:0]   head;
  logic [5:0]    shift;
  logic          silence;
  logic [23:0]   chan_out [2];

  assign in_ready   = (count_reg != CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign write      = primed_reg & write_ready & (count_reg != '0);
  assign pop        = write;
  assign fifo_count = count_reg;
  assign underflow  = underflow_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Sample storage carries no reset; the output is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_left, in_right};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      primed_reg    <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      if (count_next >= CW'(DEPTH / 2)) begin
        primed_reg <= 1'b1;
      end
      if (primed_reg && write_ready && count_reg == '0) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign head    = mem[rd_ptr_reg];
  assign shift   = {3'b000, volume} + {1'b0, att_reg};
  // A shift of 24 or more forces exact zero so negative samples leave no -1 residue.
  assign silence = (state_reg == MUTED) || (shift >= 6'd24) || (count_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [23:0] sample;
      logic signed [23:0] shifted;
      assign sample       = head[gi*24 +: 24];
      assign shifted      = sample >>> shift;
      assign chan_out[gi] = silence ? 24'd0 : shifted;
    end
  endgenerate

  assign writedata_right = chan_out[0];
  assign writedata_left  = chan_out[1];

`ifdef SOUND_FADE_EN
  localparam int PCW = (FADE_SAMPLES > 1) ? $clog2(FADE_SAMPLES) : 1;
  localparam logic [PCW-1:0] POP_LAST = PCW'(FADE_SAMPLES - 1);

  logic [PCW-1:0] pop_cnt_reg;
  logic           step;

  assign step = pop && (pop_cnt_reg == POP_LAST);

  // Fades advance only on pops, so a stalled codec freezes the ramp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= PLAY;
      att_reg     <= '0;
      pop_cnt_reg <= '0;
    end else begin
      case (state_reg)
        PLAY: begin
          att_reg <= '0;
          if (mute) begin
            state_reg   <= FADE_OUT;
            pop_cnt_reg <= '0;
          end
        end
        FADE_OUT: begin
          if (!mute) begin
            state_reg   <= FADE_IN;
            pop_cnt_reg <= '0;
          end else if (att_reg >= ATT_MAX) begin
            state_reg <= MUTED;
          end else if (pop) begin
            pop_cnt_reg <= step ? '0 : pop_cnt_reg + PCW'(1);
            if (step) begin
              att_reg <= att_reg + 5'd1;
              if (att_reg == ATT_MAX - 5'd1) begin
                state_reg <= MUTED;
              end
            end
          end
        end
        MUTED: begin
          att_reg <= ATT_MAX;
          if (!mute) begin
            state_reg   <= FADE_IN;
            pop_cnt_reg <= '0;
          end
        end
        FADE_IN: begin
          if (mute) begin
            state_reg   <= FADE_OUT;
            pop_cnt_reg <= '0;
          end else if (att_reg == '0) begin
            state_reg <= PLAY;
          end else if (pop) begin
            pop_cnt_reg <= step ? '0 : pop_cnt_reg + PCW'(1);
            if (step) begin
              att_reg <= att_reg - 5'd1;
              if (att_reg == 5'd1) begin
                state_reg <= PLAY;
              end
            end
          end
        end
        default: begin
          state_reg   <= PLAY;
          att_reg     <= '0;
          pop_cnt_reg <= '0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= PLAY;
      att_reg   <= '0;
    end else begin
      case (state_reg)
        PLAY: begin
          if (mute) begin
            state_reg <= MUTED;
            att_reg   <= ATT_MAX;
          end else begin
            att_reg <= '0;
          end
        end
        MUTED: begin
          if (!mute) begin
            state_reg <= PLAY;
            att_reg   <= '0;
          end else begin
            att_reg <= ATT_MAX;
          end
        end
        default: begin
          state_reg <= PLAY;
          att_reg   <= '0;
        end
      endcase
    end
  end
`endif

endmodule
